serial_word_source: RTL and testbench

- Upstream stage of the serial sequence detector. Converts parallel words into the 1-bit `din` stream the detector samples, one bit per enabled clock.
- Accepts words over a valid/ready handshake.
- A one-word holding register lets consecutive words stream with no idle gap.
- Provides framing strobes (`dout_valid`, `word_done`) so verification can align detector output `y` to bit positions.

---
 rtl/serial_word_source.sv | 109 ++++++++++
 tb/tb_serial_word_source.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_source.sv
// Parallel-to-serial word source feeding the sequence detector's din.
// One-word holding register keeps back-to-back words gap-free.
module serial_word_source #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             dout,
    output logic             dout_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] hold;
    logic [CW-1:0]    cnt;
    logic             hold_full;
    logic             accept;
    logic             last;

    assign load_ready = !hold_full;
    assign accept     = load_valid && load_ready;
    assign last       = (state == SHIFT) && shift_en && (cnt == LAST);

    // Move the next bit toward the output end; vacated position fills with 0.
    always_comb begin
        if (MSB_FIRST) shifted = {sreg[WIDTH-2:0], 1'b0};
        else           shifted = {1'b0, sreg[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (accept) state_next = SHIFT;
            SHIFT: if (last && !hold_full && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg      <= '0;
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                sreg <= data_in;
                cnt  <= '0;
            end
        end else begin
            if (shift_en) begin
                if (cnt == LAST) begin
                    cnt <= '0;
                    if (hold_full) begin
                        sreg      <= hold;
                        hold_full <= 1'b0;
                    end else if (accept) begin
                        sreg <= data_in;
                    end
                end else begin
                    sreg <= shifted;
                    cnt  <= cnt + CW'(1);
                end
            end
            // A word arriving on the boundary bypasses hold (handled above).
            if (accept && !last) begin
                hold      <= data_in;
                hold_full <= 1'b1;
            end
        end
    end

    always_comb begin
        dout       = IDLE_BIT;
        dout_valid = 1'b0;
        word_done  = 1'b0;
        busy       = hold_full;
        unique case (state)
            SHIFT: begin
                dout       = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
                dout_valid = 1'b1;
                word_done  = last;
                busy       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serial_word_source.sv
// Bench for serial_word_source: table vectors, corner sequences,
// and random traffic against a word/bit-position reference model.
module tb_serial_word_source;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       load_valid;
    logic       shift_en;

    logic       ready0, dout0, dv0, wd0, busy0;
    logic       ready1, dout1, dv1, wd1, busy1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: current word, bits still to send, optional queued word.
    int         m_left = 0;
    logic [7:0] m_word = '0;
    bit         m_held = 1'b0;
    logic [7:0] m_hw   = '0;

    typedef struct {
        bit         lv;
        logic [7:0] d;
        bit         se;
        bit         dout;
        bit         dout_lsb;
        bit         dv;
        bit         wd;
        bit         busy;
        bit         rdy;
    } vec_t;

    vec_t vec[10];
    bit   exp3[11];

    always #5 clk = ~clk;

    serial_word_source #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .data_in(data_in),
        .load_valid(load_valid), .load_ready(ready0),
        .shift_en(shift_en), .dout(dout0), .dout_valid(dv0),
        .word_done(wd0), .busy(busy0)
    );

    serial_word_source #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .data_in(data_in),
        .load_valid(load_valid), .load_ready(ready1),
        .shift_en(shift_en), .dout(dout1), .dout_valid(dv1),
        .word_done(wd1), .busy(busy1)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_dout(input bit msb, input bit idle);
        if (m_left == 0) return idle;
        // Bits already sent = 8 - m_left.
        if (msb) return m_word[m_left-1];
        return m_word[8-m_left];
    endfunction

    task automatic model_check();
        bit dv;
        dv = (m_left > 0);
        chk("dout_msb", dout0, m_dout(1'b1, 1'b0));
        chk("dout_lsb", dout1, m_dout(1'b0, 1'b1));
        chk("dout_valid0", dv0, dv);
        chk("dout_valid1", dv1, dv);
        chk("word_done0", wd0, dv && shift_en && m_left == 1);
        chk("word_done1", wd1, dv && shift_en && m_left == 1);
        chk("busy0", busy0, dv || m_held);
        chk("busy1", busy1, dv || m_held);
        chk("load_ready0", ready0, !m_held);
        chk("load_ready1", ready1, !m_held);
    endtask

    task automatic model_update();
        bit acc;
        bit took;
        acc  = load_valid && !m_held;
        took = 1'b0;
        if (m_left == 0) begin
            if (acc) begin
                m_word = data_in; m_left = 8; took = 1'b1;
            end
        end else if (shift_en) begin
            m_left--;
            if (m_left == 0) begin
                if (m_held) begin
                    m_word = m_hw; m_left = 8; m_held = 1'b0;
                end else if (acc) begin
                    m_word = data_in; m_left = 8; took = 1'b1;
                end
            end
        end
        if (acc && !took) begin
            m_held = 1'b1; m_hw = data_in;
        end
    endtask

    task automatic step(input bit lv, input logic [7:0] d, input bit se);
        @(posedge clk);
        #1;
        cyc++;
        load_valid = lv;
        data_in    = d;
        shift_en   = se;
        #3;
        model_check();
        model_update();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        rst = 1'b0; load_valid = 1'b0; data_in = '0; shift_en = 1'b1;

        vec[0] = '{1, 8'hB5, 1, 0, 1, 0, 0, 0, 1};
        vec[1] = '{0, 8'h00, 1, 1, 1, 1, 0, 1, 1};
        vec[2] = '{0, 8'h00, 1, 0, 0, 1, 0, 1, 1};
        vec[3] = '{0, 8'h00, 1, 1, 1, 1, 0, 1, 1};
        vec[4] = '{0, 8'h00, 1, 1, 0, 1, 0, 1, 1};
        vec[5] = '{0, 8'h00, 1, 0, 1, 1, 0, 1, 1};
        vec[6] = '{0, 8'h00, 1, 1, 1, 1, 0, 1, 1};
        vec[7] = '{0, 8'h00, 1, 0, 0, 1, 0, 1, 1};
        vec[8] = '{0, 8'h00, 1, 1, 1, 1, 1, 1, 1};
        vec[9] = '{0, 8'h00, 1, 0, 1, 0, 0, 0, 1};
        exp3   = '{1, 0, 1, 1, 1, 1, 1, 0, 1, 0, 1};

        #1;
        chk("rst_dout0", dout0, 1'b0);
        chk("rst_dout1", dout1, 1'b1);
        chk("rst_valid", dv0, 1'b0);
        chk("rst_done", wd0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_ready", ready0, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Single word, both bit orders and idle levels
        foreach (vec[i]) begin
            step(vec[i].lv, vec[i].d, vec[i].se);
            chk("t1_dout", dout0, vec[i].dout);
            chk("t6_dout_lsb", dout1, vec[i].dout_lsb);
            chk("t1_valid", dv0, vec[i].dv);
            chk("t1_done", wd0, vec[i].wd);
            chk("t1_busy", busy0, vec[i].busy);
            chk("t1_ready", ready0, vec[i].rdy);
        end
        idle(3);

        // Back-to-back with hold register full
        cyc = -1;
        for (int c = 0; c <= 26; c++) begin
            step(c == 0 || (c >= 2 && c <= 9),
                 c == 0 ? 8'hB5 : (c == 2 ? 8'h3C : 8'hFF), 1'b1);
            chk("t2_done", wd0, c == 8 || c == 16 || c == 24);
            chk("t2_valid", dv0, c >= 1 && c <= 24);
            if (c >= 3 && c <= 9) chk("t2_ready", ready0, c == 9);
        end
        idle(2);

        // Stall in the middle of a word
        cyc = -1;
        for (int c = 0; c <= 13; c++) begin
            step(c == 0, 8'hB5, !(c >= 3 && c <= 5));
            if (c >= 1 && c <= 11) chk("t3_dout", dout0, exp3[c-1]);
            chk("t3_done", wd0, c == 11);
        end
        idle(2);

        // Bypass on the last-bit cycle
        cyc = -1;
        for (int c = 0; c <= 18; c++) begin
            step(c == 0 || c == 8, c == 0 ? 8'hB5 : 8'h81, 1'b1);
            if (c >= 1 && c <= 16) chk("t4_valid", dv0, 1'b1);
            if (c == 8 || c == 9) chk("t4_ready", ready0, 1'b1);
            if (c == 9) chk("t4_dout", dout0, 1'b1);
        end
        idle(2);

        // Reset mid-word with a word held
        cyc = -1;
        step(1'b1, 8'hB5, 1'b1);
        step(1'b1, 8'h3C, 1'b1);
        idle(3);
        #1 rst = 1'b0;
        load_valid = 1'b0;
        #1;
        chk("t5_dout0", dout0, 1'b0);
        chk("t5_dout1", dout1, 1'b1);
        chk("t5_valid", dv0, 1'b0);
        chk("t5_busy", busy0, 1'b0);
        chk("t5_ready", ready0, 1'b1);
        m_left = 0;
        m_held = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("t5_quiet", dv0, 1'b0);
        end

        // Random traffic against the model
        for (int c = 0; c < 600; c++)
            step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 3) != 0);
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
